// File: rtl/hex_display_ctrl_if.sv
// Bus between the board top and the hex display controller: channel words and
// display controls in, segment drives and status out.
interface hex_display_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int DIGITS = 8
);
  localparam int CW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DIGITS*4-1:0] ch_data;
  logic [CW-1:0]              sel;
  logic [1:0]                 mode;
  logic                       lz_blank;
  logic                       blink_en;
  logic [DIGITS*7-1:0]        hex_out;
  logic [CW-1:0]              cur_ch;
  logic                       frozen;

  modport master (
    output ch_data, sel, mode, lz_blank, blink_en,
    input  hex_out, cur_ch, frozen
  );

  modport slave (
    input  ch_data, sel, mode, lz_blank, blink_en,
    output hex_out, cur_ch, frozen
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-channel active-low hex display controller with manual/auto/freeze channel
// selection, leading-zero blanking and blink; all outputs registered.
module hex_display_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int DIGITS       = 8,
  parameter int ROTATE_TICKS = 50_000_000,
  parameter int BLINK_TICKS  = 25_000_000
) (
  input  logic              clock,
  input  logic              reset,
  hex_display_ctrl_if.slave bus
);
  localparam int CW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
  localparam int RW = $clog2(ROTATE_TICKS);
  localparam int BW = $clog2(BLINK_TICKS);
  localparam int W  = DIGITS * 4;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_FREEZE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0011000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic [W-1:0]        ch_words [NUM_CH];
  logic [31:0]         sel_ext;

  logic [DIGITS*7-1:0] hex_out_reg, hex_next;
  logic [CW-1:0]       cur_ch_reg, cur_ch_next;
  logic                frozen_reg, frozen_next;
  logic [RW-1:0]       rot_cnt_reg, rot_cnt_next;
  logic [BW-1:0]       blink_cnt_reg, blink_cnt_next;
  logic                blink_phase_reg, blink_phase_next;
  logic [W-1:0]        shown_reg, shown_next;
  mode_e               prev_mode_reg, prev_mode_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_words[gi] = bus.ch_data[gi*W +: W];
    end
  endgenerate

  assign sel_ext = 32'(bus.sel);

  always_comb begin
    cur_ch_next      = cur_ch_reg;
    shown_next       = shown_reg;
    frozen_next      = 1'b0;
    rot_cnt_next     = '0;
    blink_cnt_next   = '0;
    blink_phase_next = 1'b1;
    prev_mode_next   = mode_e'(bus.mode);

    case (mode_e'(bus.mode))
      MODE_AUTO: begin
        if (rot_cnt_reg == RW'(ROTATE_TICKS - 1)) begin
          cur_ch_next = (cur_ch_reg == CW'(NUM_CH - 1)) ? '0 : cur_ch_reg + CW'(1);
        end else begin
          rot_cnt_next = rot_cnt_reg + RW'(1);
        end
        shown_next = ch_words[cur_ch_next];
      end
      MODE_FREEZE: begin
        // Snapshot only on the entry edge; afterwards the display ignores ch_data/sel.
        frozen_next = 1'b1;
        if (prev_mode_reg != MODE_FREEZE) begin
          shown_next = ch_words[cur_ch_reg];
        end
      end
      default: begin
        if (sel_ext < 32'(NUM_CH)) begin
          cur_ch_next = bus.sel;
          shown_next  = ch_words[bus.sel];
        end
      end
    endcase

    if (bus.blink_en) begin
      if (blink_cnt_reg == BW'(BLINK_TICKS - 1)) begin
        blink_phase_next = ~blink_phase_reg;
      end else begin
        blink_cnt_next   = blink_cnt_reg + BW'(1);
        blink_phase_next = blink_phase_reg;
      end
    end
  end

  // Decode from the next shown value so hex_out lags the inputs by one edge only.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic lz_hit;
      if (gi == 0) begin : g_first
        assign lz_hit = 1'b0;
      end else begin : g_upper
        assign lz_hit = bus.lz_blank && (shown_next[W-1:gi*4] == '0);
      end
      assign hex_next[gi*7 +: 7] = (!blink_phase_next || lz_hit) ? 7'h7F
                                                                 : seg7(shown_next[gi*4 +: 4]);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      hex_out_reg     <= '1;
      cur_ch_reg      <= '0;
      frozen_reg      <= 1'b0;
      rot_cnt_reg     <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
      shown_reg       <= '0;
      prev_mode_reg   <= MODE_MANUAL;
    end else begin
      hex_out_reg     <= hex_next;
      cur_ch_reg      <= cur_ch_next;
      frozen_reg      <= frozen_next;
      rot_cnt_reg     <= rot_cnt_next;
      blink_cnt_reg   <= blink_cnt_next;
      blink_phase_reg <= blink_phase_next;
      shown_reg       <= shown_next;
      prev_mode_reg   <= prev_mode_next;
    end
  end

  assign bus.hex_out = hex_out_reg;
  assign bus.cur_ch  = cur_ch_reg;
  assign bus.frozen  = frozen_reg;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized self-checking bench for hex_display_ctrl against a cycle-count based
// reference model (rotation/blink phase derived from elapsed cycles).
module tb_hex_display_ctrl;
  localparam int NUM_CH = 4;
  localparam int DIGITS = 8;
  localparam int RT     = 4;
  localparam int BT     = 3;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clock = 1'b0;
  logic reset = 1'b1;

  hex_display_ctrl_if #(.NUM_CH(NUM_CH), .DIGITS(DIGITS)) bus ();

  hex_display_ctrl #(
    .NUM_CH(NUM_CH), .DIGITS(DIGITS), .ROTATE_TICKS(RT), .BLINK_TICKS(BT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_shown;
  logic [55:0] m_hex;
  int m_cur, m_prev, m_frozen, auto_k, auto_start, blink_k;

  function automatic logic [31:0] ch_word(input int c);
    return bus.ch_data[c*32 +: 32];
  endfunction

  function automatic logic [55:0] exp_hex(input logic [31:0] v, input logic lz, input logic vis);
    logic [55:0] r;
    for (int d = 0; d < DIGITS; d++) begin
      logic [31:0] nib;
      nib = (v >> (4 * d)) & 32'hF;
      if (!vis || (lz && d > 0 && (v >> (4 * d)) == 0)) r[d*7 +: 7] = 7'h7F;
      else r[d*7 +: 7] = SEG[nib[3:0]];
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] v;
    v = $urandom;
    return v >> ($urandom_range(0, 8) * 4);
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_hex = '1; m_cur = 0; m_frozen = 0; m_shown = '0; m_prev = 0;
      auto_k = 0; auto_start = 0; blink_k = 0;
    end else begin
      case (bus.mode)
        2'b01: begin
          auto_k++;
          m_cur = (auto_start + auto_k / RT) % NUM_CH;
          m_shown = ch_word(m_cur);
          m_frozen = 0;
        end
        2'b10: begin
          if (m_prev != 2) m_shown = ch_word(m_cur);
          m_frozen = 1;
        end
        default: begin
          m_frozen = 0;
          if (int'(bus.sel) < NUM_CH) begin
            m_cur = int'(bus.sel);
            m_shown = ch_word(m_cur);
          end
        end
      endcase
      if (bus.mode != 2'b01) begin
        auto_k = 0;
        auto_start = m_cur;
      end
      blink_k = bus.blink_en ? blink_k + 1 : 0;
      m_hex = exp_hex(m_shown, bus.lz_blank, ((blink_k / BT) % 2) == 0);
      m_prev = int'(bus.mode);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    model_edge();
  endtask

  task automatic randomize_channels();
    for (int c = 0; c < NUM_CH; c++) bus.ch_data[c*32 +: 32] = rand_word();
  endtask

  task automatic test_reset();
    bus.ch_data = '0; bus.sel = '0; bus.mode = 2'b00; bus.lz_blank = 1'b0; bus.blink_en = 1'b0;
    bus.ch_data[31:0] = 32'h1234ABCD;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.hex_out !== {56{1'b1}}) begin
        errors++; $display("FAIL reset_hex cycle %0d got %h want all ones", i, bus.hex_out);
      end
      checks++;
      if (bus.cur_ch !== 2'd0 || bus.frozen !== 1'b0) begin
        errors++; $display("FAIL reset_status got cur_ch=%0d frozen=%b want 0/0", bus.cur_ch, bus.frozen);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.hex_out[6:0] !== 7'b0100001 || bus.hex_out[55:49] !== 7'b1111001) begin
      errors++; $display("FAIL release_digits got d0=%b d7=%b want 0100001/1111001",
                         bus.hex_out[6:0], bus.hex_out[55:49]);
    end
    checks++;
    if (bus.hex_out !== m_hex || bus.cur_ch !== 2'd0) begin
      errors++; $display("FAIL release_full got %h cur=%0d want %h cur=0", bus.hex_out, bus.cur_ch, m_hex);
    end
    $display("reset: hex=%h cur_ch=%0d", bus.hex_out, bus.cur_ch);
  endtask

  task automatic test_manual();
    bus.ch_data[64 +: 32] = 32'hDEADBEEF;
    bus.sel = 2'd2;
    tick();
    checks++;
    if (bus.hex_out !== exp_hex(32'hDEADBEEF, 1'b0, 1'b1) || bus.cur_ch !== 2'd2) begin
      errors++; $display("FAIL manual_sel2 got %h cur=%0d want DEADBEEF pattern cur=2", bus.hex_out, bus.cur_ch);
    end
    $display("manual: sel=2 hex=%h cur_ch=%0d", bus.hex_out, bus.cur_ch);
    for (int i = 0; i < 20; i++) begin
      randomize_channels();
      bus.sel = 2'($urandom_range(0, 3));
      bus.mode = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      tick();
      checks++;
      if (bus.hex_out !== m_hex || int'(bus.cur_ch) != m_cur || bus.frozen !== 1'b0) begin
        errors++; $display("FAIL manual_rand got %h cur=%0d want %h cur=%0d", bus.hex_out, bus.cur_ch, m_hex, m_cur);
      end
      $display("manual: mode=%b sel=%0d hex=%h", bus.mode, bus.sel, bus.hex_out);
    end
  endtask

  task automatic test_auto();
    bus.mode = 2'b00; bus.sel = 2'd2;
    tick();
    bus.mode = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      randomize_channels();
      bus.sel = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (int'(bus.cur_ch) != (2 + k / RT) % NUM_CH) begin
        errors++; $display("FAIL auto_cur k=%0d got %0d want %0d", k, bus.cur_ch, (2 + k / RT) % NUM_CH);
      end
      checks++;
      if (bus.hex_out !== m_hex) begin
        errors++; $display("FAIL auto_hex k=%0d got %h want %h", k, bus.hex_out, m_hex);
      end
      $display("auto: k=%0d cur_ch=%0d hex=%h", k, bus.cur_ch, bus.hex_out);
    end
  endtask

  task automatic test_freeze();
    bus.mode = 2'b00; bus.sel = 2'd1; bus.ch_data[32 +: 32] = 32'h00000050;
    tick();
    bus.mode = 2'b10;
    tick();
    checks++;
    if (bus.frozen !== 1'b1 || bus.hex_out !== exp_hex(32'h50, 1'b0, 1'b1)) begin
      errors++; $display("FAIL freeze_entry got frozen=%b hex=%h", bus.frozen, bus.hex_out);
    end
    bus.ch_data[32 +: 32] = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      bus.sel = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (bus.frozen !== 1'b1 || bus.hex_out !== exp_hex(32'h50, 1'b0, 1'b1) || bus.cur_ch !== 2'd1) begin
        errors++; $display("FAIL freeze_hold got frozen=%b hex=%h cur=%0d", bus.frozen, bus.hex_out, bus.cur_ch);
      end
      $display("freeze: hold hex=%h frozen=%b", bus.hex_out, bus.frozen);
    end
    bus.mode = 2'b00; bus.sel = 2'd1;
    tick();
    checks++;
    if (bus.frozen !== 1'b0 || bus.hex_out !== exp_hex(32'hFFFFFFFF, 1'b0, 1'b1)) begin
      errors++; $display("FAIL freeze_exit got frozen=%b hex=%h", bus.frozen, bus.hex_out);
    end
    $display("freeze: exit hex=%h frozen=%b", bus.hex_out, bus.frozen);
  endtask

  task automatic test_lz_blank();
    bus.lz_blank = 1'b1; bus.mode = 2'b00; bus.sel = 2'd1; bus.ch_data[32 +: 32] = 32'h00000050;
    tick();
    checks++;
    if (bus.hex_out[55:14] !== {42{1'b1}} || bus.hex_out[13:7] !== 7'b0010010 || bus.hex_out[6:0] !== 7'b1000000) begin
      errors++; $display("FAIL lz_50 got %h", bus.hex_out);
    end
    bus.ch_data[32 +: 32] = 32'h0;
    tick();
    checks++;
    if (bus.hex_out[55:7] !== {49{1'b1}} || bus.hex_out[6:0] !== 7'b1000000) begin
      errors++; $display("FAIL lz_zero got %h want single 0", bus.hex_out);
    end
    $display("lz: zero hex=%h", bus.hex_out);
    for (int i = 0; i < 20; i++) begin
      randomize_channels();
      bus.sel = 2'($urandom_range(0, 3));
      bus.lz_blank = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (bus.hex_out !== m_hex) begin
        errors++; $display("FAIL lz_rand got %h want %h", bus.hex_out, m_hex);
      end
      $display("lz: lz=%b hex=%h", bus.lz_blank, bus.hex_out);
    end
    bus.lz_blank = 1'b0;
  endtask

  task automatic test_blink();
    bus.mode = 2'b00; bus.sel = 2'd0; bus.ch_data[31:0] = 32'h89ABCDEF;
    bus.blink_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.hex_out !== m_hex) begin
        errors++; $display("FAIL blink_seq i=%0d got %h want %h", i, bus.hex_out, m_hex);
      end
      $display("blink: i=%0d hex=%h", i, bus.hex_out);
    end
    // Advance into a blank phase, then reset there.
    for (int i = 0; i < 6 && m_hex !== {56{1'b1}}; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.hex_out !== {56{1'b1}}) begin
      errors++; $display("FAIL blink_reset got %h want all ones", bus.hex_out);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.hex_out !== exp_hex(32'h89ABCDEF, 1'b0, 1'b1) || bus.hex_out !== m_hex) begin
      errors++; $display("FAIL blink_restart got %h want %h", bus.hex_out, m_hex);
    end
    $display("blink: restart hex=%h", bus.hex_out);
    bus.blink_en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 3) randomize_channels();
      if ($urandom_range(0, 9) < 2) bus.mode = 2'($urandom_range(0, 3));
      bus.sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) bus.lz_blank = ~bus.lz_blank;
      if ($urandom_range(0, 19) == 0) bus.blink_en = ~bus.blink_en;
      reset = ($urandom_range(0, 49) == 0);
      tick();
      checks++;
      if (bus.hex_out !== m_hex || int'(bus.cur_ch) != m_cur || int'(bus.frozen) != m_frozen) begin
        errors++; $display("FAIL random i=%0d got %h cur=%0d fr=%b want %h cur=%0d fr=%0d",
                           i, bus.hex_out, bus.cur_ch, bus.frozen, m_hex, m_cur, m_frozen);
      end
      $display("random: i=%0d rst=%b mode=%b sel=%0d hex=%h cur=%0d", i, reset, bus.mode, bus.sel, bus.hex_out, bus.cur_ch);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_freeze();
    test_lz_blank();
    test_blink();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
